// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state encoding and illegal-op boundary for alu_seq.
// The boundary moves up to include DIV when ALU_SEQ_DIV_EN is defined.
package alu_seq_pkg;
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_MUL = 4'd7;
   localparam logic [3:0] OP_DIV = 4'd8;
`ifdef ALU_SEQ_DIV_EN
   localparam logic [3:0] OP_LAST = OP_DIV;
`else
   localparam logic [3:0] OP_LAST = OP_MUL;
`endif
endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: WIDTH-iteration shift-add multiplier; restoring unsigned divider
// added when ALU_SEQ_DIV_EN is defined. o_done flags the final iteration's cycle.
module alu_seq_iter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_start,
`ifdef ALU_SEQ_DIV_EN
   input  logic             i_div,
`endif
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
);
   localparam int CW = $clog2(WIDTH) + 1;
   logic [CW-1:0]    r_cnt;
   logic             r_run;
   logic [WIDTH-1:0] r_a, r_b, r_acc, w_a_nxt, w_b_nxt, w_acc_nxt;
`ifdef ALU_SEQ_DIV_EN
   logic             r_div;
   logic [WIDTH:0]   w_sh;
   logic [WIDTH-1:0] w_sub;
   assign w_sh  = {r_acc, r_a[WIDTH-1]};
   assign w_sub = w_sh[WIDTH-1:0] - r_b;
`endif
   assign o_done = r_run && r_cnt == CW'(WIDTH - 1);
   // r_a doubles as the shifting multiplicand or the dividend/quotient register
   always_comb begin
      w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
      w_a_nxt   = r_a << 1;
      w_b_nxt   = r_b >> 1;
      o_result  = w_acc_nxt;
`ifdef ALU_SEQ_DIV_EN
      if (r_div) begin
         w_a_nxt   = {r_a[WIDTH-2:0], w_sh >= {1'b0, r_b}};
         w_acc_nxt = w_sh >= {1'b0, r_b} ? w_sub : w_sh[WIDTH-1:0];
         w_b_nxt   = r_b;
         o_result  = w_a_nxt;
      end
`endif
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_run <= 1'b0;
         r_cnt <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
`ifdef ALU_SEQ_DIV_EN
         r_div <= 1'b0;
`endif
      end else if (i_start) begin
         r_run <= 1'b1;
         r_cnt <= '0;
         r_a   <= i_a;
         r_b   <= i_b;
         r_acc <= '0;
`ifdef ALU_SEQ_DIV_EN
         r_div <= i_div;
`endif
      end else if (r_run) begin
         r_a   <= w_a_nxt;
         r_b   <= w_b_nxt;
         r_acc <= w_acc_nxt;
         r_cnt <= r_cnt + 1'b1;
         r_run <= !o_done;
      end
   end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU, single-cycle ops via IDLE->DONE, MUL (and DIV when
// ALU_SEQ_DIV_EN is defined) via IDLE->BUSY->DONE using alu_seq_iter.
import alu_seq_pkg::*;

module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             z,
   output logic             n,
   output logic             c,
   output logic             err
);
   localparam int SW = $clog2(WIDTH);
   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_out, w_res, w_iter_res;
   logic [WIDTH:0]   w_sum, w_dif;
   logic             r_z, r_n, r_c, r_err;
   logic             w_c, w_illegal, w_iter_op, w_iter_done, w_iter_err, w_accept;
   assign w_sum     = {1'b0, in1} + {1'b0, in2};
   assign w_dif     = {1'b0, in1} - {1'b0, in2};
   assign w_illegal = alu_op > OP_LAST;
   assign w_accept  = in_valid && in_ready;
   assign w_res = alu_op == OP_ADD ? w_sum[WIDTH-1:0] :
                  alu_op == OP_SUB ? w_dif[WIDTH-1:0] :
                  alu_op == OP_AND ? in1 & in2 :
                  alu_op == OP_OR  ? in1 | in2 :
                  alu_op == OP_XOR ? in1 ^ in2 :
                  alu_op == OP_SHL ? in1 << in2[SW-1:0] :
                  alu_op == OP_SHR ? in1 >> in2[SW-1:0] : '0;
   assign w_c = alu_op == OP_ADD ? w_sum[WIDTH] : alu_op == OP_SUB ? w_dif[WIDTH] : 1'b0;
`ifdef ALU_SEQ_DIV_EN
   logic r_div0;
   assign w_iter_op  = alu_op == OP_MUL || alu_op == OP_DIV;
   assign w_iter_err = r_div0;
   always_ff @(posedge clk)
      r_div0 <= !reset_n ? 1'b0 : w_accept ? (alu_op == OP_DIV && in2 == '0) : r_div0;
`else
   assign w_iter_op  = alu_op == OP_MUL;
   assign w_iter_err = 1'b0;
`endif
   alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_start  (w_accept && w_iter_op),
`ifdef ALU_SEQ_DIV_EN
      .i_div    (alu_op == OP_DIV),
`endif
      .i_a      (in1),
      .i_b      (in2),
      .o_done   (w_iter_done),
      .o_result (w_iter_res)
   );
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = reset_n;
            if (in_valid && reset_n) w_state_nxt = w_iter_op ? S_BUSY : S_DONE;
         end
         S_BUSY: if (w_iter_done) w_state_nxt = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_out   <= '0;
         r_z     <= 1'b0;
         r_n     <= 1'b0;
         r_c     <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept && !w_iter_op) begin
            r_out <= w_res;
            r_z   <= w_res == '0;
            r_n   <= w_res[WIDTH-1];
            r_c   <= w_c;
            r_err <= w_illegal;
         end else if (r_state == S_BUSY && w_iter_done) begin
            r_out <= w_iter_res;
            r_z   <= w_iter_res == '0;
            r_n   <= w_iter_res[WIDTH-1];
            r_c   <= 1'b0;
            r_err <= w_iter_err;
         end
      end
   end
   assign alu_out = r_out;
   assign z       = r_z;
   assign n       = r_n;
   assign c       = r_c;
   assign err     = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=16) against an
// arithmetic reference model; honours ALU_SEQ_DIV_EN when defined.
module tb_alu_seq;
   localparam int W = 16;
   logic          clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic          in_ready, out_valid, z, n, c, err;
   logic [W-1:0]  in1 = '0, in2 = '0, alu_out;
   logic [3:0]    alu_op = '0;
   int            total = 0, bad = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .alu_op(alu_op), .out_valid(out_valid),
      .out_ready(out_ready), .alu_out(alu_out), .z(z), .n(n), .c(c), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic void model(input int op, input longint unsigned a, b,
                                 output longint unsigned r, output bit cy, output bit e, output int lat);
      longint unsigned m = 64'd1 << W;
      cy = 0; e = 0; lat = 1;
      case (op)
         0: begin r = (a + b) % m; cy = (a + b) >= m; end
         1: begin r = (a + m - b) % m; cy = a < b; end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (a << (b % W)) % m;
         6: r = a >> (b % W);
         7: begin r = (a * b) % m; lat = W + 1; end
`ifdef ALU_SEQ_DIV_EN
         8: begin lat = W + 1; if (b == 0) begin r = m - 1; e = 1; end else r = a / b; end
`endif
         default: begin r = 0; e = 1; end
      endcase
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, b, input bit hold_valid,
                         output int lat, output bit ready_low);
      int k = 0;
      while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
      alu_op = op; in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      if (!hold_valid) in_valid = 1'b0;
      lat = 1; ready_low = 1;
      while (!out_valid && lat < 60) begin
         if (in_ready) ready_low = 0;
         @(posedge clk); #1; lat++;
      end
      if (in_ready) ready_low = 0;
      in_valid = 1'b0;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({in_ready, out_valid, alu_out, z, n, c, err} !== '0) begin
         bad++;
         $display("FAIL reset_state: got rdy=%b vld=%b out=%h znce=%b%b%b%b want all 0",
                  in_ready, out_valid, alu_out, z, n, c, err);
      end
      reset_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add();
      int lat; bit rl;
      run_op(4'd0, 16'd6, 16'd2, 0, lat, rl);
      total++;
      if ({alu_out, z, n, c, err} !== {16'd8, 4'b0000} || lat != 1) begin
         bad++;
         $display("FAIL add_6_2: got out=%h znce=%b%b%b%b lat=%0d want out=0008 znce=0000 lat=1",
                  alu_out, z, n, c, err, lat);
      end
      release_out();
   endtask

   task automatic test_sub();
      int lat; bit rl;
      run_op(4'd1, 16'd2, 16'd4, 0, lat, rl);
      total++;
      if ({alu_out, z, n, c, err} !== {16'hFFFE, 4'b0110} || lat != 1) begin
         bad++;
         $display("FAIL sub_2_4: got out=%h znce=%b%b%b%b lat=%0d want out=fffe znce=0110 lat=1",
                  alu_out, z, n, c, err, lat);
      end
      release_out();
   endtask

   task automatic test_mul();
      int lat; bit rl;
      run_op(4'd7, 16'd6, 16'd2, 1, lat, rl);
      total++;
      if (alu_out !== 16'd12 || err !== 1'b0 || lat != W + 1) begin
         bad++;
         $display("FAIL mul_6_2: got out=%h err=%b lat=%0d want out=000c err=0 lat=17", alu_out, err, lat);
      end
      total++;
      if (!rl) begin bad++; $display("FAIL mul_ready_low: got in_ready=1 during busy want 0"); end
      release_out();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL mul_return_idle: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mul_no_reaccept: got vld=%b want 0", out_valid); end
   endtask

   task automatic test_hold();
      int lat; bit rl;
      run_op(4'd0, 16'hFFFF, 16'd1, 0, lat, rl);
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({out_valid, alu_out, z, c, err} !== {1'b1, 16'd0, 3'b110}) begin
            bad++;
            $display("FAIL hold_cycle%0d: got vld=%b out=%h z=%b c=%b err=%b want vld=1 out=0000 z=1 c=1 err=0",
                     i, out_valid, alu_out, z, c, err);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b1; alu_op = 4'd2; in1 = 16'hF0F0; in2 = 16'hFFFF;
      release_out();
      in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_abort();
      bit seen = 0;
      alu_op = 4'd7; in1 = 16'd300; in2 = 16'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({in_ready, out_valid, alu_out, z, n, c, err} !== '0) begin
         bad++;
         $display("FAIL abort_reset_state: got rdy=%b vld=%b out=%h znce=%b%b%b%b want all 0",
                  in_ready, out_valid, alu_out, z, n, c, err);
      end
      reset_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", in_ready); end
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      total++;
      if (seen) begin bad++; $display("FAIL abort_no_result: got out_valid=1 want never"); end
   endtask

   task automatic test_illegal();
      int lat; bit rl;
      longint unsigned r; bit cy, e; int el;
      run_op(4'd12, 16'h1234, 16'h5678, 0, lat, rl);
      total++;
      if ({alu_out, z, n, c, err} !== {16'd0, 4'b1001} || lat != 1) begin
         bad++;
         $display("FAIL illegal_op12: got out=%h znce=%b%b%b%b lat=%0d want out=0000 znce=1001 lat=1",
                  alu_out, z, n, c, err, lat);
      end
      release_out();
      model(8, 64'd1000, 64'd0, r, cy, e, el);
      run_op(4'd8, 16'd1000, 16'd0, 0, lat, rl);
      total++;
      if (alu_out !== W'(r) || err !== e || c !== 1'b0 || z !== (r == 0) || lat != el) begin
         bad++;
         $display("FAIL op8_div0: got out=%h err=%b c=%b z=%b lat=%0d want out=%h err=%b c=0 z=%b lat=%0d",
                  alu_out, err, c, z, lat, W'(r), e, r == 0, el);
      end
      release_out();
   endtask

   task automatic test_random();
      int lat, el; bit rl, cy, e;
      longint unsigned r;
      logic [3:0] op; logic [W-1:0] a, b;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         if (i % 3 == 0) op = 4'($urandom_range(5, 8));
         a = ($urandom % 5 == 0) ? 16'hFFFF : W'($urandom);
         b = ($urandom % 5 == 0) ? W'($urandom % 3) : W'($urandom);
         model(int'(op), longint'(a), longint'(b), r, cy, e, el);
         run_op(op, a, b, $urandom % 2 == 1, lat, rl);
         total++;
         if (alu_out !== W'(r)) begin
            bad++;
            $display("FAIL rand%0d_result op=%0d a=%h b=%h: got %h want %h", i, op, a, b, alu_out, W'(r));
         end
         total++;
         if ({z, n, c, err} !== {r == 0, r[W-1], cy, e}) begin
            bad++;
            $display("FAIL rand%0d_flags op=%0d a=%h b=%h: got znce=%b%b%b%b want %b%b%b%b",
                     i, op, a, b, z, n, c, err, r == 0, r[W-1], cy, e);
         end
         total++;
         if (lat != el || !rl) begin
            bad++;
            $display("FAIL rand%0d_latency op=%0d: got lat=%0d ready_low=%b want lat=%0d ready_low=1",
                     i, op, lat, rl, el);
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         release_out();
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_hold();
      test_reset_abort();
      test_illegal();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits; legal range 4..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in1  input  WIDTH  operand A.
REQ-007 in2  input  WIDTH  operand B.
REQ-008 alu_op  input  4  operation code.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 alu_out  output  WIDTH  result.
REQ-012 z, n, c, err  output  1 each  zero, negative (result MSB), carry/borrow, error.

Function
REQ-013 A request SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; in1, in2 and alu_op are captured on that edge.
REQ-014 FSM states SHALL be IDLE, BUSY and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by in2[log2(WIDTH)-1:0], 6 SHR (logical), 7 MUL (low WIDTH bits of product), 8 DIV (quotient), 9..15 illegal.
REQ-016 Ops 0-6 and illegal ops SHALL go IDLE->DONE, with out_valid asserted on the cycle after acceptance.
REQ-017 MUL SHALL go IDLE->BUSY, run exactly WIDTH shift-add iterations, then BUSY->DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-018 DONE SHALL hold alu_out and all flags stable until out_ready=1, then return to IDLE; no new request is accepted on that cycle.
REQ-019 All arithmetic is modulo 2^WIDTH; c = carry-out for ADD, c = borrow (in1<in2 unsigned) for SUB, c=0 for all other ops.
REQ-020 z = (alu_out == 0) and n = alu_out[WIDTH-1] for every op, including illegal ops.
REQ-021 Illegal opcode SHALL give alu_out=0, err=1 (z=1); err=0 for all legal ops unless stated otherwise.
REQ-022 Shift amount >= WIDTH cannot occur; only the low log2(WIDTH) bits of in2 are used.

Reset
REQ-023 With reset_n=0 at a rising edge: state=IDLE, alu_out=0, z=n=c=err=0, out_valid=0, iteration counter=0.
REQ-024 in_ready SHALL be 0 while reset_n=0 and 1 on the first cycle after release.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the operation; the pending result is discarded and never presented.

Configuration
REQ-026 Macro ALU_SEQ_DIV_EN: when defined, op 8 SHALL be an iterative restoring divide (unsigned) taking WIDTH BUSY cycles, with the same latency as MUL.
REQ-027 With ALU_SEQ_DIV_EN defined, divide by zero SHALL yield alu_out = all ones, err=1, c=0, with normal latency.
REQ-028 Without ALU_SEQ_DIV_EN, op 8 SHALL be treated as illegal per REQ-021 and no divider logic is built.

Structure
REQ-029 Package alu_seq_pkg SHALL hold the opcode constants, the FSM state encoding, and the illegal-op boundary.
REQ-030 Sub-module alu_seq_iter SHALL implement the WIDTH-cycle shift-add multiplier (and divider when enabled), with start/done ports and a clog2(WIDTH)+1-bit counter; the top holds the FSM, single-cycle datapath and output registers.

Verification
REQ-031 WIDTH=16, in1=6, in2=2, ADD -> alu_out=8, z=n=c=err=0, out_valid on cycle +1.
REQ-032 in1=2, in2=4, SUB -> alu_out=0xFFFE, n=1, c=1, z=0.
REQ-033 in1=6, in2=2, MUL with out_ready=1 -> in_ready=0 for 17 cycles, alu_out=12 at out_valid (cycle +17); in_valid held high during BUSY is not accepted.
REQ-034 ADD 0xFFFF+1 with out_ready=0 for 5 cycles -> alu_out=0, z=1, c=1 held stable for all 5 cycles; in_ready=1 on the cycle after out_ready rises.
REQ-035 MUL accepted, reset_n=0 at cycle +5 -> out_valid never rises for that request, outputs=0, in_ready=1 after release.
REQ-036 alu_op=12 -> alu_out=0, err=1, z=1; op 8 with in2=0 -> 0xFFFF, err=1 (DIV_EN) or alu_out=0, err=1 (no DIV_EN).
